// File: rtl/dfd_te_pkt_packer.sv
// ----------------------------------------------------------------------------
// dfd_te_pkt_packer
//
// Packs variable-length trace packets (0..PKT_BYTES bytes each) into a gapless
// stream of WORD_BYTES-wide output words. Bytes are kept in a small byte
// buffer. Whole words go out as soon as they exist. A flush request drains
// every buffered byte, and the last word may be a partial word.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. pkt_ready and out_valid come from registered state only and
// never depend combinationally on pkt_valid or out_ready. While out_valid is
// high and out_ready is low, out_data and out_be hold their values.
//
// Ports:
//   clk, reset_n          clock, synchronous active-low reset
//   pkt_valid/pkt_ready   input packet handshake
//   pkt_data              packet bytes, byte i = bits [8i+7:8i], byte 0 first
//   pkt_data_len          number of valid bytes (0..PKT_BYTES)
//   pkt_data_be           byte enables, used only for a consistency check
//   flush_req             pulse: drain everything, including a partial word
//   out_valid/out_ready   output word handshake
//   out_data, out_be      packed word and its contiguous valid-byte mask
//   flush_done            one-cycle pulse when a flush has fully drained
//   fill_level            bytes currently buffered
//   pkt_err               sticky protocol error (bad length or byte enables)
// ----------------------------------------------------------------------------
module dfd_te_pkt_packer #(
    parameter int PKT_BYTES  = 32,
    parameter int WORD_BYTES = 8,
    parameter int BUF_BYTES  = 64
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      pkt_valid,
    output logic                      pkt_ready,
    input  logic [PKT_BYTES*8-1:0]    pkt_data,
    input  logic [$clog2(PKT_BYTES+1)-1:0] pkt_data_len,
    input  logic [PKT_BYTES-1:0]      pkt_data_be,
    input  logic                      flush_req,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WORD_BYTES*8-1:0]   out_data,
    output logic [WORD_BYTES-1:0]     out_be,
    output logic                      flush_done,
    output logic [$clog2(BUF_BYTES+1)-1:0] fill_level,
    output logic                      pkt_err
);

    localparam int FW = $clog2(BUF_BYTES + 1);
    localparam int LW = $clog2(PKT_BYTES + 1);

    // NORMAL: accept packets and emit only whole words.
    // DRAIN : a flush is pending. Packets are refused and partial words go out.
    typedef enum logic {
        NORMAL = 1'b0,
        DRAIN  = 1'b1
    } mode_e;

    mode_e           mode_q, mode_d;
    logic [7:0]      buf_q [BUF_BYTES];
    logic [7:0]      buf_d [BUF_BYTES];
    logic [7:0]      pkt_bytes [PKT_BYTES];
    logic [FW-1:0]   fill_q;
    logic [FW-1:0]   next_fill;
    logic [FW-1:0]   pop_cnt;
    logic [FW-1:0]   base;
    logic [FW-1:0]   eff_len;
    logic [PKT_BYTES:0]   be_full;
    logic [PKT_BYTES-1:0] be_exp;
    logic            push;
    logic            err;
    logic            rdy_en_q;
    logic            flush_done_q;
    logic            flush_done_d;
    logic            pkt_err_q;

    // ------------------------------------------------------------------
    // Registered-state outputs
    // ------------------------------------------------------------------
    // rdy_en_q keeps pkt_ready low while reset is held and for the first
    // edge after release.
    assign pkt_ready  = rdy_en_q && (mode_q == NORMAL) &&
                        (fill_q <= FW'(BUF_BYTES - PKT_BYTES));
    assign out_valid  = (fill_q >= FW'(WORD_BYTES)) ||
                        ((mode_q == DRAIN) && (fill_q != '0));
    assign fill_level = fill_q;
    assign flush_done = flush_done_q;
    assign pkt_err    = pkt_err_q;

    // Lanes at or above fill are forced to zero, so a partial word is clean.
    always_comb begin
        out_data = '0;
        out_be   = '0;
        for (int b = 0; b < WORD_BYTES; b++) begin
            out_be[b] = (FW'(b) < fill_q);
            if (FW'(b) < fill_q) begin
                out_data[8*b +: 8] = buf_q[b];
            end
        end
    end

    always_comb begin
        for (int j = 0; j < PKT_BYTES; j++) begin
            pkt_bytes[j] = pkt_data[8*j +: 8];
        end
    end

    // ------------------------------------------------------------------
    // Pop / push datapath
    // ------------------------------------------------------------------
    always_comb begin
        pop_cnt = '0;
        if (out_valid && out_ready) begin
            pop_cnt = (fill_q >= FW'(WORD_BYTES)) ? FW'(WORD_BYTES) : fill_q;
        end
        base = fill_q - pop_cnt;
        push = pkt_valid && pkt_ready;

        // Byte enables must be exactly the low len bits.
        be_full = ({{PKT_BYTES{1'b0}}, 1'b1} << pkt_data_len) - 1'b1;
        be_exp  = be_full[PKT_BYTES-1:0];
        err     = push && ((pkt_data_len > LW'(PKT_BYTES)) ||
                           (pkt_data_be != be_exp));

        // A bad packet still completes its handshake but stores nothing.
        eff_len   = (push && !err) ? FW'(pkt_data_len) : '0;
        next_fill = base + eff_len;

        // Below base: surviving old bytes shifted down by pop_cnt.
        // From base to next_fill: the new packet's bytes.
        // Above next_fill: zero, so the buffer never holds stale bytes.
        for (int i = 0; i < BUF_BYTES; i++) begin
            int src;
            int off;
            src      = i + int'(pop_cnt);
            off      = i - int'(base);
            buf_d[i] = '0;
            if (FW'(i) < base) begin
                if (src < BUF_BYTES) begin
                    buf_d[i] = buf_q[src];
                end
            end else if (FW'(i) < next_fill) begin
                if (off >= 0 && off < PKT_BYTES) begin
                    buf_d[i] = pkt_bytes[off];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Mode FSM: next state
    // ------------------------------------------------------------------
    // A flush_req that arrives while already draining merges into the
    // pending flush. A packet accepted in the flush_req cycle is counted in
    // next_fill, so it is part of the drain.
    always_comb begin
        mode_d       = mode_q;
        flush_done_d = 1'b0;
        if ((mode_q == DRAIN) || flush_req) begin
            if (next_fill == '0) begin
                mode_d       = NORMAL;
                flush_done_d = 1'b1;
            end else begin
                mode_d       = DRAIN;
            end
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mode_q       <= NORMAL;
            fill_q       <= '0;
            rdy_en_q     <= 1'b0;
            flush_done_q <= 1'b0;
            pkt_err_q    <= 1'b0;
            for (int i = 0; i < BUF_BYTES; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            mode_q       <= mode_d;
            fill_q       <= next_fill;
            rdy_en_q     <= 1'b1;
            flush_done_q <= flush_done_d;
            if (err) begin
                pkt_err_q <= 1'b1;
            end
            for (int i = 0; i < BUF_BYTES; i++) begin
                buf_q[i] <= buf_d[i];
            end
        end
    end

endmodule

// File: doc/dfd_te_pkt_packer.md
Name: dfd_te_pkt_packer

Overview:
- Downstream of the trace encoder's packet formatter. Accepts variable-length packets of 0..32 bytes each, carried as the team's packet buffer record: byte-enable, length, and 256-bit data.
- Packs the bytes, with no gaps, into a stream of 64-bit words with valid/ready handshake. Partial words are emitted on flush.
- Output feeds the message-output (MSO) stage at MSO_DATA_IN_WIDTH.

Parameters:
- PKT_BYTES, 32, maximum input packet size in bytes (NTRACE_MAX_PACKET_WIDTH_IN_BYTES).
- WORD_BYTES, 8, output word size in bytes (MSO_DATA_IN_WIDTH/8).
- BUF_BYTES, 64, internal byte-buffer capacity. Must be >= PKT_BYTES+WORD_BYTES.

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous active-low reset
- pkt_valid  in  1  input packet valid
- pkt_ready  out  1  packer can accept a packet this cycle
- pkt_data  in  256  packet bytes; byte i = bits [8i+7:8i]; byte 0 is sent first
- pkt_data_len  in  6  number of valid bytes, 0..32
- pkt_data_be  in  32  byte enables; checked only, never used for packing
- flush_req  in  1  pulse: drain all buffered bytes, including a partial word
- out_valid  out  1  output word valid
- out_ready  in  1  downstream accepts the word
- out_data  out  64  packed word; byte 0 = bits [7:0]
- out_be  out  8  valid-byte mask, contiguous from bit 0
- flush_done  out  1  one-cycle pulse when a flush completes
- fill_level  out  7  bytes currently buffered
- pkt_err  out  1  sticky protocol-error flag

Behaviour:
- Reset (reset_n=0 at a clk edge):
  - fill=0, buffer zeroed, flush_pending=0, pkt_err=0.
  - pkt_ready=0 during reset. out_valid=0, out_data=0, out_be=0, flush_done=0, fill_level=0.
  - Reset asserted mid-operation discards all buffered data with no output.
- State:
  - Byte array buf[BUF_BYTES], fill counter, flush_pending bit.
  - Two modes: NORMAL (flush_pending=0) and DRAIN (flush_pending=1).
- Input ready:
  - pkt_ready = (fill <= BUF_BYTES-PKT_BYTES), registered-state based only.
  - pkt_ready has no combinational dependence on pkt_valid or out_ready.
- Output, driven from registers only:
  - out_valid = (fill>=WORD_BYTES) | (flush_pending & fill>0).
  - out_data = buf[7:0]. Byte lanes at or above fill are driven 0.
  - out_be = 8'hFF if fill>=8, else (1<<fill)-1.
- Pop (out_valid & out_ready): remove pop = min(fill,8) bytes; remaining bytes shift down by pop.
- Push (pkt_valid & pkt_ready): append pkt_data_len bytes starting at index fill-pop.
- Next fill = fill - pop + len. Pop and push in the same cycle are both honoured.
- Latency: bytes accepted at edge N can appear on out_data at N+1 at the earliest.
- pkt_data_len=0 with valid: handshake completes, no data stored.
- Errors:
  - Condition: pkt_data_len>32, or pkt_data_be != (1<<len)-1 on an accepted packet.
  - Response: set pkt_err, sticky until reset. The packet is dropped (len treated as 0).
- Flush:
  - flush_req sets flush_pending. A packet accepted in the same cycle is included in the flush.
  - While flush_pending is set, pkt_ready is forced to 0.
  - flush_pending clears, and flush_done pulses for one cycle, at the edge where next fill==0.
  - flush_req while fill==0 with no push: flush_done pulses the next cycle.
  - flush_req while already pending: ignored.
- Backpressure: out_ready=0 holds out_data/out_be/out_valid stable. Input stalls once fill > BUF_BYTES-PKT_BYTES.
- fill never exceeds BUF_BYTES (64). Worst case is 32+32=64, so no overflow is possible by construction.

Test Plan:
- Reset, then one packet len=3, data 0xCCBBAA, out_ready=1 -> out_valid stays 0 (fill=3). Pulse flush_req -> next cycle out_data=0x0000000000CCBBAA, out_be=8'h07; then flush_done pulse, fill_level=0.
- Packets len=5 (bytes 0x01..0x05) then len=5 (0x06..0x0A), out_ready=1 -> word 0x0807060504030201, be=FF. Then flush -> 0x0A09, be=03.
- out_ready=0, send 32-byte packets continuously -> 2 accepted (fill=64), pkt_ready=0, out_data stable. Raise out_ready -> 8 words in order, bytes 0..63 match, pkt_ready reasserts at fill<=32.
- Same-cycle pop and push: fill=9, push len=7 while popping -> fill_level=8, the new bytes follow byte 8 exactly.
- len=33, or be=0xF with len=3 -> pkt_err=1 (sticky), fill_level unchanged. len=0 -> accepted, no effect.
- Reset asserted mid-stream with fill=20 and flush_pending=1 -> all outputs 0 on the next cycle, no flush_done, subsequent packet packs from byte 0.
